// File: rtl/multiplier_arbiter_pkg.sv
// Shared constants for the multiplier arbiter: requester count and FSM state encoding.
package multiplier_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

endpackage

// File: rtl/multiplier_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
import multiplier_arbiter_pkg::*;

module rr_arbiter2 (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_grant
);

  logic                r_fav;
  logic [NUM_REQ-1:0]  w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (i_req == 2'b11) begin
      w_grant = r_fav ? 2'b10 : 2'b01;
    end else begin
      w_grant = i_req;
    end
  end

  // r_fav names the requester that wins the next tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fav <= 1'b0;
    end else if (i_update && (w_grant != 2'b00)) begin
      r_fav <= w_grant[0];
    end else begin
      r_fav <= r_fav;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one multiplier between two requesters: grant, issue, wait for result, respond.
// Optional WAIT timeout is enabled with macro MULTIPLIER_ARBITER_TIMEOUT_EN.
import multiplier_arbiter_pkg::*;

module multiplier_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*WIDTH-1:0]     req_a,
  input  logic [2*WIDTH-1:0]     req_b,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [WIDTH-1:0]       mul_result,
  input  logic                   mul_done,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [WIDTH-1:0]       resp_result,
  output logic                   resp_error,
  output logic                   busy
);

  state_e             r_state;
  logic               r_mul_start;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_resp_valid;
  logic               r_resp_id;
  logic [WIDTH-1:0]   r_resp_result;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_en;
  logic               w_grant_id;

`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_resp_error;
`endif

  assign w_grant_en = (r_state == ST_IDLE) && (req_valid != 2'b00);
  assign w_grant_id = w_grant[1];

  rr_arbiter2 u_rr (
    .clock    (clock),
    .reset    (reset),
    .i_req    (req_valid),
    .i_update (w_grant_en),
    .o_grant  (w_grant)
  );

  // Grant is combinational so the requester sees ready in the decision cycle.
  assign req_ready = (r_state == ST_IDLE) ? w_grant : 2'b00;

  // Main FSM with operand latches and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mul_start   <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= '0;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_resp_error  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_en) begin
            r_mul_a     <= w_grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            r_mul_b     <= w_grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            r_resp_id   <= w_grant_id;
            r_mul_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mul_start <= 1'b0;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
          r_wait_cnt  <= '0;
`endif
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving in the timeout cycle still wins.
          if (mul_done) begin
            r_resp_result <= mul_result;
            r_resp_valid  <= 1'b1;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
            r_resp_error  <= 1'b0;
`endif
            r_state       <= ST_RESPOND;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
          end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_resp_result <= '0;
            r_resp_valid  <= 1'b1;
            r_resp_error  <= 1'b1;
            r_state       <= ST_RESPOND;
          end else begin
            r_wait_cnt    <= r_wait_cnt + 1'b1;
`endif
          end
        end
        ST_RESPOND: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mul_start   = r_mul_start;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign busy        = (r_state != ST_IDLE);

`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
  assign resp_error = r_resp_error;
`else
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Self-checking bench for multiplier_arbiter: directed vector table, corner sequences, random run.
module tb_multiplier_arbiter;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*W-1:0] req_a, req_b;
  logic          mul_start;
  logic [W-1:0]  mul_a, mul_b, mul_result;
  logic          mul_done;
  logic          resp_valid, resp_ready, resp_id, resp_error, busy;
  logic [W-1:0]  resp_result;

  multiplier_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_done(mul_done), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_error(resp_error), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Behavioural shared multiplier: pulses done a chosen number of cycles after start.
  int          mdl_cnt = 0;
  bit          mdl_en = 1'b1;
  bit          mdl_rand = 1'b0;
  int          mdl_delay = 1;
  bit          mdl_ovr = 1'b0;
  logic [W-1:0] mdl_ovr_val = '0;
  logic [W-1:0] mdl_res = '0;
  int          inj_tok = 0;
  int          inj_seen = 0;

  initial begin
    mul_done = 1'b0;
    mul_result = '0;
    forever begin
      @(posedge clock);
      #1;
      mul_done = 1'b0;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          mul_done = 1'b1;
          mul_result = mdl_res;
        end
      end
      if (inj_tok != inj_seen) begin
        inj_seen = inj_tok;
        mul_done = 1'b1;
        mul_result = 32'h0000_1234;
      end
      if (mul_start && mdl_en) begin
        mdl_cnt = mdl_rand ? int'($urandom_range(1, 5)) : mdl_delay;
        mdl_res = mdl_ovr ? mdl_ovr_val : mul_a * mul_b;
      end
    end
  end

  int start_cnt = 0;
  always @(negedge clock) if (mul_start) start_cnt++;

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] a0, b0, a1, b1;
    int           delay;
    bit           ovr;
    logic [W-1:0] ovr_val;
    int           bp;
    logic         exp_id;
    logic [W-1:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int s0;
    logic [W-1:0] ea, eb;
    logic [W-1:0] held;
    mdl_en = 1'b1; mdl_rand = 1'b0; mdl_delay = v.delay;
    mdl_ovr = v.ovr; mdl_ovr_val = v.ovr_val;
    ea = v.exp_id ? v.a1 : v.a0;
    eb = v.exp_id ? v.b1 : v.b0;
    s0 = start_cnt;
    req_valid = v.valid; req_a = {v.a1, v.a0}; req_b = {v.b1, v.b0}; resp_ready = 1'b0;
    #1;
    chk($sformatf("v%0d grant", idx), 64'(req_ready), v.exp_id ? 64'd2 : 64'd1);
    step();
    req_valid = 2'b00;
    #1;
    chk($sformatf("v%0d mul_start", idx), 64'(mul_start), 64'd1);
    chk($sformatf("v%0d mul_a", idx), 64'(mul_a), 64'(ea));
    chk($sformatf("v%0d mul_b", idx), 64'(mul_b), 64'(eb));
    cyc = 1;
    while (!resp_valid && cyc < 50) begin
      step();
      cyc++;
    end
    chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.delay + 2));
    chk($sformatf("v%0d resp_id", idx), 64'(resp_id), 64'(v.exp_id));
    chk($sformatf("v%0d resp_result", idx), 64'(resp_result), 64'(v.exp_res));
    chk($sformatf("v%0d resp_error", idx), 64'(resp_error), 64'd0);
    held = resp_result;
    for (int k = 0; k < v.bp; k++) begin
      req_valid = 2'b11;
      #1;
      chk("bp resp_valid", 64'(resp_valid), 64'd1);
      chk("bp resp_result", 64'(resp_result), 64'(held));
      chk("bp resp_id", 64'(resp_id), 64'(v.exp_id));
      chk("bp req_ready", 64'(req_ready), 64'd0);
      step();
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
    chk($sformatf("v%0d released", idx), {62'd0, resp_valid, busy}, 64'd0);
    chk($sformatf("v%0d one start", idx), 64'(start_cnt - s0), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {mul_a, 23'd0, mul_start, req_ready, resp_valid, resp_id, resp_error, busy, 1'b0},
        64'd0);
    chk({name, " result/b"}, {resp_result, mul_b}, 64'd0);
  endtask

  typedef struct { logic id; logic [W-1:0] a, b; } exp_t;
  exp_t q[$];

  initial begin
    int cyc;
    bit ref_idle;
    logic ref_fav;
    logic [1:0] exp_rdy;
    logic [W-1:0] p;
    exp_t e;

    reset = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; resp_ready = 1'b0;
    #12;
    chk_reset_outputs("reset state");
    step();
    reset = 1'b0;
    #1;

    vecs[0] = '{2'b11, 32'd6, 32'd7, 32'd8, 32'd9, 4, 1'b0, 32'd0, 0, 1'b0, 32'd42};
    vecs[1] = '{2'b11, 32'd1, 32'd1, 32'd3, 32'd5, 2, 1'b0, 32'd0, 5, 1'b1, 32'd15};
    vecs[2] = '{2'b10, 32'd4, 32'd4, 32'd9, 32'd11, 3, 1'b0, 32'd0, 0, 1'b1, 32'd99};
    vecs[3] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'd2, 32'd2, 2, 1'b1, 32'd0, 0, 1'b0, 32'd0};
    vecs[4] = '{2'b11, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'd2, 3, 1'b1, 32'hFFFF_FFFE, 0, 1'b1,
                32'hFFFF_FFFE};
    vecs[5] = '{2'b11, 32'd100, 32'd3, 32'd7, 32'd7, 1, 1'b0, 32'd0, 0, 1'b0, 32'd300};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Timeout behaviour: multiplier never answers.
    mdl_en = 1'b0;
    req_valid = 2'b01; req_a = {32'd0, 32'd3}; req_b = {32'd0, 32'd3};
    step();
    req_valid = 2'b00;
    cyc = 1;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
    while (!resp_valid && cyc < 50) begin
      step();
      cyc++;
    end
    chk("timeout latency", 64'(cyc), 64'd10);
    chk("timeout error", 64'(resp_error), 64'd1);
    chk("timeout result", 64'(resp_result), 64'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
`else
    while (!resp_valid && cyc < 30) begin
      step();
      cyc++;
    end
    chk("no timeout resp_valid", 64'(resp_valid), 64'd0);
    chk("no timeout busy", 64'(busy), 64'd1);
`endif

    // Reset in WAIT, then a late mul_done must be ignored.
    do_reset();
    req_valid = 2'b10; req_a = {32'd5, 32'd0}; req_b = {32'd6, 32'd0};
    step();
    req_valid = 2'b00;
    step();
    step();
    chk("in wait busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("async reset");
    step();
    reset = 1'b0;
    inj_tok++;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post reset no resp", {62'd0, resp_valid, busy}, 64'd0);
    end
    chk_reset_outputs("post reset state");

    // Random traffic against a transaction-level reference.
    do_reset();
    mdl_en = 1'b1; mdl_rand = 1'b1; mdl_ovr = 1'b0;
    ref_idle = 1'b1; ref_fav = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c < 570) begin
        req_valid = 2'($urandom_range(0, 3));
        resp_ready = 1'($urandom_range(0, 1));
      end else begin
        req_valid = 2'b00;
        resp_ready = 1'b1;
      end
      req_a = {$urandom(), $urandom()};
      req_b = {$urandom(), $urandom()};
      #1;
      exp_rdy = 2'b00;
      if (ref_idle && req_valid != 2'b00) begin
        if (req_valid == 2'b11) e.id = ref_fav;
        else e.id = req_valid[1];
        exp_rdy = e.id ? 2'b10 : 2'b01;
      end
      chk("rand req_ready", 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy != 2'b00) begin
        e.a = e.id ? req_a[2*W-1:W] : req_a[W-1:0];
        e.b = e.id ? req_b[2*W-1:W] : req_b[W-1:0];
        q.push_back(e);
        ref_fav = ~e.id;
        ref_idle = 1'b0;
      end
      if (mul_start) begin
        if (q.size() == 0) chk("rand spurious start", 64'd1, 64'd0);
        else chk("rand operands", {mul_a, mul_b}, {q[0].a, q[0].b});
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("rand spurious resp", 64'd1, 64'd0);
        end else begin
          p = q[0].a * q[0].b;
          chk("rand resp", {30'd0, resp_error, resp_id, resp_result}, {31'd0, q[0].id, p});
          if (resp_ready) begin
            void'(q.pop_front());
            ref_idle = 1'b1;
          end
        end
      end
      step();
    end
    chk("rand drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
